// File: rtl/seq_event_logger.sv
// seq_event_logger: edge-detects Y1/Y2, timestamps each event into an FWFT FIFO, keeps counters.
// Optional registered irq output when EVT_IRQ_EN is defined.
module seq_event_logger #(
    parameter int DEPTH      = 4,
    parameter int TS_W       = 8,
    parameter int CNT_W      = 4,
    parameter int IRQ_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Y1,
    input  logic             Y2,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_src,
    output logic [TS_W-1:0]  evt_ts,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow,
    output logic             fifo_full,
    output logic             fifo_empty
`ifdef EVT_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_IRQ = (AW+1)'(IRQ_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic y1_q, y2_q, rise1, rise2, push, pop, accept, drop;
    logic [TS_W-1:0] ts;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] occ;
    logic [1:0] src_mem [DEPTH];
    logic [TS_W-1:0] ts_mem [DEPTH];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        rise1 = Y1 & ~y1_q;
        rise2 = Y2 & ~y2_q;
        push = (rise1 | rise2) & ~clear;
        pop = evt_valid & evt_ready & ~clear;
        accept = push & (~fifo_full | pop);
        drop = push & fifo_full & ~pop;
    end

    assign evt_valid = occ != '0;
    assign fifo_empty = ~evt_valid;
    assign fifo_full = occ == OCC_FULL;
    assign evt_src = evt_valid ? src_mem[rptr] : '0;
    assign evt_ts = evt_valid ? ts_mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            src_mem[wptr] <= {rise2, rise1};
            ts_mem[wptr] <= ts;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y1_q <= 1'b0;
            y2_q <= 1'b0;
            ts <= '0;
            wptr <= '0;
            rptr <= '0;
            occ <= '0;
            count1 <= '0;
            count2 <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            y1_q <= Y1;
            y2_q <= Y2;
            if (clear) begin
                ts <= '0;
                wptr <= '0;
                rptr <= '0;
                occ <= '0;
                count1 <= '0;
                count2 <= '0;
                drop_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                ts <= ts + 1'b1;
                if (accept) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
                if (accept != pop) occ <= accept ? occ + 1'b1 : occ - 1'b1;
                if (rise1 && count1 != CNT_MAX) count1 <= count1 + 1'b1;
                if (rise2 && count2 != CNT_MAX) count2 <= count2 + 1'b1;
                if (drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
                if (drop) overflow <= 1'b1;
            end
        end
    end

`ifdef EVT_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else irq <= clear ? 1'b0 : (occ >= OCC_IRQ) | overflow;
    end
`endif
endmodule

// File: tb/tb_seq_event_logger.sv
// tb_seq_event_logger: table vectors plus scoreboard of expected FIFO entries for seq_event_logger.
module tb_seq_event_logger;
    logic clk = 1'b0, reset, Y1, Y2, clear, evt_ready;
    logic evt_valid, overflow, fifo_full, fifo_empty;
    logic [1:0] evt_src;
    logic [7:0] evt_ts;
    logic [3:0] count1, count2, drop_cnt;
`ifdef EVT_IRQ_EN
    logic irq;
`endif

    seq_event_logger #(.DEPTH(4), .TS_W(8), .CNT_W(4), .IRQ_THRESH(2)) dut (
        .clk(clk), .reset(reset), .Y1(Y1), .Y2(Y2), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_src(evt_src), .evt_ts(evt_ts),
        .count1(count1), .count2(count2), .drop_cnt(drop_cnt), .overflow(overflow),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef EVT_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] src; logic [7:0] ts; } ent_t;
    typedef struct { logic y1, y2, rdy, clr, vld; int c1, c2; } vec_t;

    ent_t sbq[$];
    int checks = 0, failures = 0;
    int ts_m, c1m, c2m, dropm, guard;
    bit ovfm, y1p, y2p;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare the head about to leave, then advance the reference model
    task automatic tick();
        bit r1, r2, pop;
        r1 = Y1 & ~y1p;
        r2 = Y2 & ~y2p;
        pop = evt_ready && sbq.size() > 0 && !clear;
        chk("valid", evt_valid, int'(sbq.size() != 0));
        if (pop) begin
            chk("head_src", evt_src, sbq[0].src);
            chk("head_ts", evt_ts, sbq[0].ts);
        end else if (sbq.size() == 0) chk("empty_head_zero", {evt_src, evt_ts}, 0);
        @(posedge clk);
        #1;
        if (clear) begin
            sbq.delete();
            {c1m, c2m, dropm, ts_m} = '0;
            ovfm = 0;
        end else begin
            if (pop) void'(sbq.pop_front());
            if (r1 | r2) begin
                if (sbq.size() < 4) sbq.push_back('{{r2, r1}, 8'(ts_m)});
                else begin
                    if (dropm < 15) dropm++;
                    ovfm = 1;
                end
            end
            if (r1 && c1m < 15) c1m++;
            if (r2 && c2m < 15) c2m++;
            ts_m = (ts_m + 1) % 256;
        end
        y1p = Y1;
        y2p = Y2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {Y1, Y2, clear, evt_ready} = '0;
        #2;
        chk("rst_valid", evt_valid, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_counts", {count1, count2, drop_cnt}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_head", {evt_src, evt_ts}, 0);
`ifdef EVT_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        sbq.delete();
        {c1m, c2m, dropm, ts_m} = '0;
        {ovfm, y1p, y2p} = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rise(input bit use_y2);
        if (use_y2) Y2 = 1'b1; else Y1 = 1'b1;
        tick();
        {Y1, Y2} = 2'b00;
        tick();
    endtask

    task automatic model_chk();
        chk("count1_model", count1, c1m);
        chk("count2_model", count2, c2m);
        chk("drop_model", drop_cnt, dropm);
        chk("overflow_model", overflow, int'(ovfm));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[6] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[7] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 1, 0};
        tbl[9] = '{1, 1, 0, 0, 1, 2, 1};
        tbl[10] = '{1, 1, 1, 0, 0, 2, 1};
        tbl[11] = '{0, 0, 1, 0, 0, 2, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            {Y1, Y2, evt_ready, clear} = {tbl[i].y1, tbl[i].y2, tbl[i].rdy, tbl[i].clr};
            tick();
            chk($sformatf("vec%0d_valid", i), evt_valid, tbl[i].vld);
            chk($sformatf("vec%0d_count1", i), count1, tbl[i].c1);
            chk($sformatf("vec%0d_count2", i), count2, tbl[i].c2);
        end

        // Overflow: five Y2 rises with the consumer stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            Y2 = 1'b1;
            tick();
            if (i == 3) chk("full_after_4", fifo_full, 1);
            Y2 = 1'b0;
            tick();
        end
        chk("drop_cnt_1", drop_cnt, 1);
        chk("overflow_set", overflow, 1);
        chk("count2_5", count2, 5);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drained_empty", fifo_empty, 1);

        // Full FIFO with simultaneous pop and push
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) rise(0);
        chk("refull", fifo_full, 1);
        Y1 = 1'b1;
        evt_ready = 1'b1;
        tick();
        chk("full_pop_push_full", fifo_full, 1);
        chk("full_pop_push_drop", drop_cnt, 1);
        Y1 = 1'b0;
        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("drain2_empty", fifo_empty, 1);

        // Saturation and timestamp wrap
        for (int i = 0; i < 20; i++) rise(0);
        chk("count1_sat", count1, 15);
        model_chk();
        evt_ready = 1'b0;
        tick();
        guard = 0;
        while (ts_m != 255 && guard < 600) begin
            tick();
            guard++;
        end
        Y1 = 1'b1;
        tick();
        Y1 = 1'b0;
        Y2 = 1'b1;
        tick();
        Y2 = 1'b0;
        chk("wrap_head_ts", evt_ts, 255);
        chk("wrap_head_src", evt_src, 1);
        evt_ready = 1'b1;
        tick();
        chk("wrap_next_ts", evt_ts, 0);
        chk("wrap_next_src", evt_src, 2);
        tick();

        // Clear coincident with a Y2 rise while two entries are queued
        evt_ready = 1'b0;
        rise(0);
        rise(0);
        chk("two_queued", fifo_empty, 0);
        Y2 = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_empty", fifo_empty, 1);
        chk("clear_counts", {count1, count2, drop_cnt}, 0);
        chk("clear_overflow", overflow, 0);
        Y1 = 1'b1;
        tick();
        Y1 = 1'b0;
        chk("post_clear_ts", evt_ts, 0);
        chk("post_clear_count2", count2, 0);
        model_chk();

        // Fresh run: irq timing, then an asynchronous reset mid-stream
        do_reset();
        Y1 = 1'b1;
        tick();
        Y1 = 1'b0;
        tick();
        Y1 = 1'b1;
        tick();
`ifdef EVT_IRQ_EN
        chk("irq_not_yet", irq, 0);
`endif
        Y1 = 1'b0;
        tick();
`ifdef EVT_IRQ_EN
        chk("irq_high", irq, 1);
`endif
        chk("two_entries", count1, 2);
        do_reset();
        tick();
        chk("after_reset_empty", fifo_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
